// File: rtl/stereo_sample_queue_if.sv
// stereo_sample_queue_if: sample-write and burst-readout signals of the stereo sample queue.
// master = sample producer / burst consumer side, slave = the queue itself.
interface stereo_sample_queue_if #(
    parameter int unsigned DATA_W = 16
);
    logic                     wrt_smpl;
    logic signed [DATA_W-1:0] lft_smpl;
    logic signed [DATA_W-1:0] rght_smpl;
    logic signed [DATA_W-1:0] lft_out;
    logic signed [DATA_W-1:0] rght_out;
    logic                     sequencing;
    logic                     overrun;

    modport master (
        output wrt_smpl,
        output lft_smpl,
        output rght_smpl,
        input  lft_out,
        input  rght_out,
        input  sequencing,
        input  overrun
    );

    modport slave (
        input  wrt_smpl,
        input  lft_smpl,
        input  rght_smpl,
        output lft_out,
        output rght_out,
        output sequencing,
        output overrun
    );
endinterface

// File: rtl/stereo_sample_queue.sv
// stereo_sample_queue: 1024-entry stereo ring feeding the FIR stages. Once DEPTH pairs are held,
// each accepted sample triggers a burst readout of the newest DEPTH pairs, oldest first, with
// `sequencing` high while the read data is valid.
// Optional feature: define CQUEUE_OVERRUN_EN to make `overrun` a sticky flag for samples dropped
// because they arrived during a burst; otherwise `overrun` is tied low (samples still dropped).
module stereo_sample_queue #(
    parameter int unsigned DEPTH  = 1021,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PTR_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    stereo_sample_queue_if.slave bus
);
    localparam int unsigned      RingSize = 2 ** PTR_W;
    localparam logic [PTR_W-1:0] DepthW   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] DepthM1  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StFill,
        StIdle,
        StLoad,
        StRead
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    count_q;
    logic [PTR_W-1:0]    rd_cnt_q;
    logic                seq_q;
    logic [2*DATA_W-1:0] mem [RingSize];
    logic [2*DATA_W-1:0] rd_data_q;
    logic                wr_en;
    logic                rd_en;

    assign rd_en = (state_q == StRead);

    // Accept a sample only while filling, or when idle after the previous burst has fully drained
    // (the trailing `sequencing` cycle after READ still counts as part of the burst).
    always_comb begin
        wr_en = 1'b0;
        if (bus.wrt_smpl) begin
            wr_en = (state_q == StFill) || ((state_q == StIdle) && !seq_q);
        end
    end

    // Control FSM: pointers, fill count, burst issue counter and the registered sequencing strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_cnt_q <= '0;
            seq_q    <= 1'b0;
        end else begin
            // Issue strobe delayed one cycle to line up with the synchronous read data.
            seq_q <= rd_en;
            unique case (state_q)
                StFill: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_q + 1'b1;
                        if (count_q == DepthM1) begin
                            state_q <= StLoad;
                        end
                    end
                end
                StIdle: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    // Oldest of the newest DEPTH pairs; wraps modulo the ring size.
                    rd_ptr_q <= wr_ptr_q - DepthW;
                    rd_cnt_q <= '0;
                    state_q  <= StRead;
                end
                StRead: begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_cnt_q == DepthM1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    // Ring write port; contents are never cleared, only overwritten before being read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= {bus.lft_smpl, bus.rght_smpl};
        end
    end

    // Synchronous read port; the output register holds its value between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign bus.lft_out    = rd_data_q[2*DATA_W-1:DATA_W];
    assign bus.rght_out   = rd_data_q[DATA_W-1:0];
    assign bus.sequencing = seq_q;

`ifdef CQUEUE_OVERRUN_EN
    logic overrun_q;
    logic drop;

    assign drop = bus.wrt_smpl && !wr_en;

    // Sticky flag: set on the first dropped sample, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_stereo_sample_queue.sv
// tb_stereo_sample_queue: directed stimulus with a scoreboard. Stimulus pushes the expected burst
// contents when a sample triggers a burst; a negedge monitor pops and compares on `sequencing`.
module tb_stereo_sample_queue;
    localparam int unsigned DEPTH = 1021;
    localparam int unsigned DW    = 16;
`ifdef CQUEUE_OVERRUN_EN
    localparam bit ExpOvr = 1'b1;
`else
    localparam bit ExpOvr = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stereo_sample_queue_if #(.DATA_W(DW)) bus ();

    stereo_sample_queue #(
        .DEPTH (DEPTH),
        .DATA_W(DW),
        .PTR_W (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    smp_t exp_q[$];
    smp_t hist[$];
    int   checks  = 0;
    int   errors  = 0;
    int   run_len = 0;
    bit   cut     = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: remember accepted pairs; once DEPTH are held, each one queues a burst.
    task automatic model_accept(input logic [DW-1:0] l, input logic [DW-1:0] r);
        smp_t s;
        s.l = l;
        s.r = r;
        hist.push_back(s);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (hist.size() == DEPTH) begin
            foreach (hist[j]) exp_q.push_back(hist[j]);
        end
    endtask

    task automatic pulse(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit acc);
        bus.wrt_smpl  = 1'b1;
        bus.lft_smpl  = l;
        bus.rght_smpl = r;
        tick();
        bus.wrt_smpl = 1'b0;
        if (acc) model_accept(l, r);
    endtask

    // Burst-triggering sample: checks start latency and burst length, returns at the first
    // cycle a new sample may be accepted.
    task automatic trig(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pulse(l, r, 1'b1);
        tick();
        chk("seq_low_n2", 32'(bus.sequencing), 0);
        tick();
        chk("seq_high_n3", 32'(bus.sequencing), 1);
        repeat (DEPTH) tick();
        chk("seq_low_after_burst", 32'(bus.sequencing), 0);
    endtask

    // Monitor: every sequencing cycle must match the next expected pair.
    always @(negedge clk) begin
        smp_t e;
        if (bus.sequencing) begin
            run_len++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_seq: actual lft=%0h rght=%0h required=no burst at %0t",
                         bus.lft_out, bus.rght_out, $time);
            end else begin
                e = exp_q.pop_front();
                if ({bus.lft_out, bus.rght_out} !== {e.l, e.r}) begin
                    errors++;
                    $display("FAIL burst_data: actual lft=%0h rght=%0h required lft=%0h rght=%0h at %0t",
                             bus.lft_out, bus.rght_out, e.l, e.r, $time);
                end
            end
        end else if (run_len != 0) begin
            if (!cut) begin
                checks++;
                if (run_len != DEPTH) begin
                    errors++;
                    $display("FAIL burst_len: actual=%0d required=%0d", run_len, DEPTH);
                end
            end
            run_len = 0;
            cut     = 1'b0;
        end
    end

    initial begin
        logic [DW-1:0] v;
        bus.wrt_smpl  = 1'b0;
        bus.lft_smpl  = '0;
        bus.rght_smpl = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_lft_out", 32'(bus.lft_out), 0);
        chk("rst_rght_out", 32'(bus.rght_out), 0);
        chk("rst_seq", 32'(bus.sequencing), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        rst = 1'b0;
        tick();

        // Fill: no burst until the DEPTH-th sample
        for (int i = 0; i < DEPTH - 1; i++) begin
            pulse(16'(i), 16'(-i), 1'b1);
            tick();
        end
        trig(16'd1020, 16'(-1020));

        // Samples 1021..1024: wr_ptr wraps 1023 -> 0; first one at the earliest legal cycle
        for (int i = 1021; i <= 1024; i++) begin
            trig(16'(i), 16'(-i));
        end

        // Sample arriving 500 cycles into a burst is dropped
        chk("overrun_pre", 32'(bus.overrun), 0);
        pulse(16'd1025, 16'(-1025), 1'b1);
        repeat (2) tick();
        repeat (499) tick();
        pulse(16'h7FFF, 16'h7FFF, 1'b0);
        repeat (521) tick();
        chk("seq_low_after_overrun_burst", 32'(bus.sequencing), 0);
        chk("overrun_flag", 32'(bus.overrun), 32'(ExpOvr));

        // Extreme values pass bit-exact
        trig(16'h8000, 16'h7FFF);
        trig(16'h7FFF, 16'h8000);

        // wrt_smpl held high: one acceptance per 1024-cycle burst period
        for (int k = 0; k < 3000; k++) begin
            v             = 16'(32'h4000 + k);
            bus.wrt_smpl  = 1'b1;
            bus.lft_smpl  = v;
            bus.rght_smpl = ~v;
            tick();
            if (k % 1024 == 0) model_accept(v, ~v);
        end
        bus.wrt_smpl = 1'b0;
        repeat (80) tick();
        chk("seq_low_after_hold", 32'(bus.sequencing), 0);

        // Reset at burst cycle 300
        pulse(16'd2000, 16'(-2000), 1'b1);
        repeat (2) tick();
        repeat (299) tick();
        cut = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        hist.delete();
        chk("seq_after_mid_reset", 32'(bus.sequencing), 0);
        chk("overrun_after_mid_reset", 32'(bus.overrun), 0);
        chk("lft_out_after_mid_reset", 32'(bus.lft_out), 0);

        // Refill: 1020 pulses silent, the 1021st bursts
        for (int i = 0; i < DEPTH - 1; i++) begin
            pulse(16'(i + 100), 16'(-(i + 100)), 1'b1);
            tick();
        end
        trig(16'd1120, 16'(-1120));

        repeat (5) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
